// File: rtl/apb_tx_pkg.sv
// Shared constants for the APB transmit buffer: register map, STATUS layout,
// CLEAR command bits and the THRESH reset value.
package apb_tx_pkg;

    localparam int unsigned ADDR_DATA   = 32'd2;
    localparam int unsigned ADDR_STATUS = 32'd5;
    localparam int unsigned ADDR_THRESH = 32'd6;
    localparam int unsigned ADDR_CLEAR  = 32'd7;

    // STATUS flag positions, counted upward from the top of the level field
    localparam int unsigned ST_EMPTY_OFS  = 32'd0;
    localparam int unsigned ST_FULL_OFS   = 32'd1;
    localparam int unsigned ST_OVF_OFS    = 32'd2;
    localparam int unsigned ST_UDF_OFS    = 32'd3;
    localparam int unsigned ST_AEMPTY_OFS = 32'd4;

    localparam int unsigned CLR_FLUSH_BIT = 32'd0;
    localparam int unsigned CLR_OVF_BIT   = 32'd1;
    localparam int unsigned CLR_UDF_BIT   = 32'd2;

    localparam int unsigned THRESH_RST = 32'd2;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a separate level counter, flush, and
// sticky overflow/underflow flags. Flush beats a same-cycle pop.
module sync_fifo_fwft #(
    parameter  int DW    = 18,
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic          i_clr_ovf,
    input  logic          i_clr_udf,
    output logic [DW-1:0] o_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [LW-1:0] o_level,
    output logic          o_overflow,
    output logic          o_underflow
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic          r_underflow;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;
    logic w_ovf_set;
    logic w_udf_set;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(DEPTH));
    // a pop frees the slot that a same-cycle push into a full FIFO needs
    assign w_pop_ok  = i_pop & ~w_empty & ~i_flush;
    assign w_push_ok = i_push & ~i_flush & (~w_full | w_pop_ok);
    assign w_ovf_set = i_push & ~i_flush & w_full & ~w_pop_ok;
    assign w_udf_set = i_pop & w_empty & ~i_flush;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level <= r_level + LW'(w_push_ok) - LW'(w_pop_ok);
        end
    end

    // Storage; cleared only by reset so the head word reads 0 out of reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Sticky error flags; a set in the same cycle as its clear wins
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (i_clr_udf) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign o_data      = r_mem[r_rd_ptr];
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_level     = r_level;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/apb_tx_fifo.sv
// APB slave front end of the transmit buffer: DATA pushes, STATUS/THRESH
// readback and CLEAR commands; the queue itself lives in sync_fifo_fwft.
module apb_tx_fifo
    import apb_tx_pkg::*;
#(
    parameter  int ADDRESSWIDTH = 3,
    parameter  int DATAWIDTH    = 18,
    parameter  int DEPTH        = 16,
    localparam int LW           = $clog2(DEPTH) + 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [ADDRESSWIDTH-1:0] PADDR_i,
    input  logic [DATAWIDTH-1:0]    PWDATA_i,
    input  logic                    PWRITE_i,
    input  logic                    PSELx_i,
    input  logic                    PENABLE_i,
    output logic [DATAWIDTH-1:0]    PRDATA_o,
    output logic                    PREADY_o,
    input  logic                    pop_i,
    output logic [DATAWIDTH-1:0]    data_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [LW-1:0]           level_o,
    output logic                    almost_empty_o
);

    logic [LW-1:0]        r_thresh;
    logic                 w_wr_acc;
    logic                 w_rd;
    logic                 w_push;
    logic                 w_clr_wr;
    logic                 w_thr_wr;
    logic                 w_flush;
    logic                 w_clr_ovf;
    logic                 w_clr_udf;
    logic [DATAWIDTH-1:0] w_data;
    logic                 w_empty;
    logic                 w_full;
    logic [LW-1:0]        w_level;
    logic                 w_overflow;
    logic                 w_underflow;
    logic                 w_aempty;
    logic [DATAWIDTH-1:0] w_status;
    logic [DATAWIDTH-1:0] w_prdata;

    // one effect per transfer: only the access phase of a write acts
    assign w_wr_acc  = PSELx_i & PENABLE_i & PWRITE_i;
    assign w_rd      = PSELx_i & ~PWRITE_i;
    assign w_push    = w_wr_acc & (PADDR_i == ADDRESSWIDTH'(ADDR_DATA));
    assign w_thr_wr  = w_wr_acc & (PADDR_i == ADDRESSWIDTH'(ADDR_THRESH));
    assign w_clr_wr  = w_wr_acc & (PADDR_i == ADDRESSWIDTH'(ADDR_CLEAR));
    assign w_flush   = w_clr_wr & PWDATA_i[CLR_FLUSH_BIT];
    assign w_clr_ovf = w_clr_wr & PWDATA_i[CLR_OVF_BIT];
    assign w_clr_udf = w_clr_wr & PWDATA_i[CLR_UDF_BIT];

    sync_fifo_fwft #(
        .DW    (DATAWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (PCLK),
        .i_rst       (PRESET),
        .i_push      (w_push),
        .i_wdata     (PWDATA_i),
        .i_pop       (pop_i),
        .i_flush     (w_flush),
        .i_clr_ovf   (w_clr_ovf),
        .i_clr_udf   (w_clr_udf),
        .o_data      (w_data),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_level     (w_level),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow)
    );

    // Almost-empty threshold register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_thresh <= LW'(THRESH_RST);
        end else if (w_thr_wr) begin
            r_thresh <= PWDATA_i[LW-1:0];
        end
    end

    assign w_aempty = (w_level <= r_thresh);

    // STATUS word assembly
    always_comb begin
        w_status                         = '0;
        w_status[LW-1:0]                 = w_level;
        w_status[LW + ST_EMPTY_OFS]      = w_empty;
        w_status[LW + ST_FULL_OFS]       = w_full;
        w_status[LW + ST_OVF_OFS]        = w_overflow;
        w_status[LW + ST_UDF_OFS]        = w_underflow;
        w_status[LW + ST_AEMPTY_OFS]     = w_aempty;
    end

    // Read mux; unmapped and write-only addresses read 0 so the top can OR sources
    always_comb begin
        w_prdata = '0;
        if (w_rd) begin
            case (PADDR_i)
                ADDRESSWIDTH'(ADDR_STATUS): w_prdata = w_status;
                ADDRESSWIDTH'(ADDR_THRESH): w_prdata = DATAWIDTH'(r_thresh);
                default:                    w_prdata = '0;
            endcase
        end else begin
            w_prdata = '0;
        end
    end

    assign PRDATA_o       = w_prdata;
    assign PREADY_o       = 1'b1;
    assign data_o         = w_data;
    assign empty_o        = w_empty;
    assign full_o         = w_full;
    assign level_o        = w_level;
    assign almost_empty_o = w_aempty;

endmodule

// File: doc/apb_tx_fifo.md
Name: apb_tx_fifo

Overview:
- APB-slave transmit buffer that sits directly upstream of the serial transmitter core on the tx APB port.
- Software writes 18-bit words to the DATA address (2). The block queues them in a first-word-fall-through FIFO.
- The serializer pops words at its own pace through a simple ready/pop interface.
- Status, threshold and clear registers are exposed on the same APB port. All logic runs in the PCLK domain.

Parameters:
- ADDRESSWIDTH, 3: APB address width.
- DATAWIDTH, 18: APB data width and FIFO word width.
- DEPTH, 16: FIFO entries. Must be a power of 2 and at least 2.
- LW, $clog2(DEPTH)+1: level counter width. Derived; not overridden.

Ports:
- PCLK  in  1  single clock, all state on its rising edge.
- PRESET  in  1  asynchronous active-high reset.
- PADDR_i  in  ADDRESSWIDTH  APB address.
- PWDATA_i  in  DATAWIDTH  APB write data.
- PWRITE_i  in  1  APB direction: 1 = write.
- PSELx_i  in  1  APB select.
- PENABLE_i  in  1  APB access phase.
- PRDATA_o  out  DATAWIDTH  APB read data.
- PREADY_o  out  1  APB ready.
- pop_i  in  1  serializer consumes the head word this cycle.
- data_o  out  DATAWIDTH  head word, valid while empty_o=0.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- level_o  out  LW  current occupancy, 0..DEPTH.
- almost_empty_o  out  1  level_o <= THRESH register.

Behaviour:
- Reset: the only clock is PCLK; reset is asynchronous and active-high on PRESET. While PRESET=1, and in the cycle after release, the outputs hold these values:
  - wr_ptr, rd_ptr and level are 0.
  - overflow and underflow sticky flags are 0.
  - THRESH is 2.
  - empty_o=1, full_o=0, level_o=0, almost_empty_o=1.
  - data_o=0, PRDATA_o=0, PREADY_o=1.
  - Reset mid-transfer drops all queued words.
- APB:
  - Zero wait states; PREADY_o is held at 1.
  - A write takes effect on the PCLK edge where PSELx_i=1, PENABLE_i=1 and PWRITE_i=1. There is exactly one effect per access phase.
  - A read returns PRDATA_o combinationally whenever PSELx_i=1 and PWRITE_i=0, in both setup and access phases. Otherwise PRDATA_o=0.
- Register map:
  - 2 DATA, write-only. Pushes PWDATA_i. Reads return 0.
  - 5 STATUS, read-only. Bits [LW-1:0] level; bit LW empty; LW+1 full; LW+2 overflow; LW+3 underflow; LW+4 almost_empty; remaining bits 0.
  - 6 THRESH, read/write. Bits [LW-1:0] are used; upper write bits are ignored and read back as 0.
  - 7 CLEAR, write-only, self-clearing, reads 0. Bit0 flushes the FIFO (pointers and level to 0; stored data is not cleared). Bit1 clears overflow. Bit2 clears underflow.
  - Addresses 0, 1, 3 and 4 belong to the serializer register file. Here, writes to them are ignored and reads return 0; the top-level ORs the PRDATA sources.
- FIFO:
  - First-word fall-through: data_o = mem[rd_ptr] combinationally.
  - Latency is 1 cycle: a pushed word appears on data_o, and empty_o falls, on the edge after the APB access phase.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate level counter drives full/empty.
- Boundary conditions:
  - Push while full, no pop: word dropped, overflow sets, level stays DEPTH.
  - Push and pop while full: both take effect, level stays DEPTH, no overflow.
  - Pop while empty: ignored, underflow sets.
  - Push and pop while empty: push accepted, pop ignored (underflow sets), level becomes 1.
  - Push and pop while partially full: level unchanged; the head advances and the new word is written.
  - Flush in the same cycle as pop: flush wins. The pop is ignored and underflow is not set. (A push and a flush cannot occur in the same cycle, since each APB access phase targets one address.)
  - Sticky set and clear in the same cycle: set wins.
  - Setting THRESH to DEPTH or more makes almost_empty_o permanently 1.

Decomposition:
- Shared package `apb_tx_pkg`:
  - register address constants ADDR_DATA=2, ADDR_STATUS=5, ADDR_THRESH=6, ADDR_CLEAR=7;
  - STATUS bit-offset constants;
  - CLEAR bit constants;
  - THRESH reset value.
- One natural sub-module, `sync_fifo_fwft`: memory, pointers, level, full/empty, sticky flags. It has push/pop/flush inputs.
- The APB decode and register logic stays in `apb_tx_fifo`.

Test Plan:
- Reset, then read STATUS (addr 5) → level=0, empty=1, full=0, almost_empty=1; PRDATA_o=0x00020 plus the almost_empty bit with DEPTH=16, i.e. 0x200 | 0x020 = 0x220.
- Write 0x001..0x003 to addr 2, pop_i=0 → level_o=3, data_o=0x001, almost_empty_o=0. Then pop three times → data_o sequence 0x001, 0x002, 0x003, then empty_o=1.
- Write 17 words 0x001..0x011 with no pops → full_o=1 after the 16th word. The 17th word is dropped and STATUS shows overflow=1. Popping everything returns 0x001..0x010. Write 0x2 to addr 7 → overflow=0.
- With the FIFO full, push 0x2AA in the same cycle as a pop → level stays 16, overflow=0, and 0x2AA is the last word popped.
- Pop while empty → underflow=1. Write 0x4 to addr 7 → underflow cleared. Write THRESH=5 and read back → 5; with 5 words queued almost_empty_o=1, with 6 queued it is 0.
- Queue 4 words, write 0x1 to addr 7 → next cycle level_o=0, empty_o=1. Next, queue 2 words and assert PRESET asynchronously mid-cycle → outputs immediately take their reset values.
